// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM for a small MIPS-like datapath.
//
// Each instruction walks IF -> ID -> (EXE_* -> MEM/WB_*) and returns to IF. The opcode is
// captured on the IF->ID edge, so changes on op at any other time have no effect. Every
// output is decoded combinationally from the registered state, the captured opcode and,
// in EXE_BR only, the Zero flag.
//
// Optional feature: define MC_JAL_EN to support jal (111010) and jr (111001), both of which
// complete in ID. Without it those opcodes are treated as illegal.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-low reset
//   op[5:0]    in   opcode from the instruction register
//   Zero       in   ALU zero flag (used in EXE_BR)
//   state[2:0] out  current state code (HALT reports 001)
//   ALUOp[2:0] out  ALU operation select
//   PCWre, IRWre, RegWre, mRD, mWR, InsMemRW   out  strobes, active high
//   ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc  out  datapath selects
//   PCSrc[1:0] out  next-PC select
//   RegDst[1:0] out write-register select
module mc_control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] op,
  input  logic       Zero,
  output logic [2:0] state,
  output logic [2:0] ALUOp,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       InsMemRW,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst
);

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpAddi = 6'b000010;
  localparam logic [5:0] OpOr   = 6'b010000;
  localparam logic [5:0] OpAnd  = 6'b010001;
  localparam logic [5:0] OpOri  = 6'b010010;
  localparam logic [5:0] OpSll  = 6'b011000;
  localparam logic [5:0] OpSlt  = 6'b100110;
  localparam logic [5:0] OpSlti = 6'b100111;
  localparam logic [5:0] OpSw   = 6'b110000;
  localparam logic [5:0] OpLw   = 6'b110001;
  localparam logic [5:0] OpBeq  = 6'b110100;
  localparam logic [5:0] OpBne  = 6'b110101;
  localparam logic [5:0] OpJ    = 6'b111000;
  localparam logic [5:0] OpHalt = 6'b111111;
`ifdef MC_JAL_EN
  localparam logic [5:0] OpJal  = 6'b111010;
  localparam logic [5:0] OpJr   = 6'b111001;
`endif

  // Low three bits of each visible state equal its external code; HALT sits outside them.
  typedef enum logic [3:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StExeLs = 4'd2,
    StMem   = 4'd3,
    StWbLd  = 4'd4,
    StExeBr = 4'd5,
    StExeAl = 4'd6,
    StWbAl  = 4'd7,
    StHalt  = 4'd8
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIf;
      op_q    <= 6'b000000;
    end else begin
      state_q <= state_d;
      if (state_q == StIf) begin
        op_q <= op;
      end
    end
  end

  // Opcode decode of the captured instruction.
  logic is_r, is_imm, is_ld, is_st, is_br, is_j, is_halt, is_jal, is_jr, ends_in_id;

  always_comb begin
    is_r    = (op_q == OpAdd) || (op_q == OpSub) || (op_q == OpOr) || (op_q == OpAnd) ||
              (op_q == OpSll) || (op_q == OpSlt);
    is_imm  = (op_q == OpAddi) || (op_q == OpOri) || (op_q == OpSlti);
    is_ld   = (op_q == OpLw);
    is_st   = (op_q == OpSw);
    is_br   = (op_q == OpBeq) || (op_q == OpBne);
    is_j    = (op_q == OpJ);
    is_halt = (op_q == OpHalt);
`ifdef MC_JAL_EN
    is_jal  = (op_q == OpJal);
    is_jr   = (op_q == OpJr);
`else
    is_jal  = 1'b0;
    is_jr   = 1'b0;
`endif
    // j, jal, jr and every illegal opcode retire in ID.
    ends_in_id = !(is_r || is_imm || is_ld || is_st || is_br || is_halt);
  end

  logic [2:0] alu_dec;

  always_comb begin
    alu_dec = 3'b000;
    unique case (1'b1)
      (op_q == OpSub) || is_br:           alu_dec = 3'b001;
      (op_q == OpSll):                    alu_dec = 3'b100;
      (op_q == OpOr) || (op_q == OpOri):  alu_dec = 3'b101;
      (op_q == OpAnd):                    alu_dec = 3'b110;
      (op_q == OpSlt) || (op_q == OpSlti): alu_dec = 3'b111;
      default:                            alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIf:    state_d = StId;
      StId: begin
        if (is_halt)             state_d = StHalt;
        else if (is_br)          state_d = StExeBr;
        else if (is_ld || is_st) state_d = StExeLs;
        else if (is_r || is_imm) state_d = StExeAl;
        else                     state_d = StIf;
      end
      StExeAl: state_d = StWbAl;
      StWbAl:  state_d = StIf;
      StExeLs: state_d = StMem;
      StMem:   state_d = is_ld ? StWbLd : StIf;
      StWbLd:  state_d = StIf;
      StExeBr: state_d = StIf;
      StHalt:  state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  always_comb begin
    state     = (state_q == StHalt) ? 3'b001 : state_q[2:0];
    ALUOp     = 3'b000;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b1;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    PCSrc     = 2'b00;
    RegDst    = 2'b00;

    // Selects only follow the captured opcode once it belongs to the current instruction.
    if ((state_q != StIf) && (state_q != StHalt)) begin
      ALUSrcA = (op_q == OpSll);
      ALUSrcB = is_imm || is_ld || is_st;
      ExtSel  = (op_q != OpOri);
      if (is_imm || is_ld) RegDst = 2'b01;
      else if (is_r)       RegDst = 2'b10;
    end

    case (state_q)
      StIf: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      StId: begin
        PCWre  = ends_in_id;
        RegWre = is_jal;
        if (is_j || is_jal) PCSrc = 2'b11;
        else if (is_jr)     PCSrc = 2'b10;
      end
      StExeAl, StExeLs: ALUOp = alu_dec;
      StWbAl: begin
        ALUOp     = alu_dec;
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
      end
      StMem: begin
        ALUOp = alu_dec;
        mRD   = is_ld;
        mWR   = is_st;
        PCWre = is_st;
      end
      StWbLd: begin
        ALUOp     = alu_dec;
        RegWre    = 1'b1;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
      end
      StExeBr: begin
        ALUOp = alu_dec;
        PCWre = 1'b1;
        if (((op_q == OpBeq) && Zero) || ((op_q == OpBne) && !Zero)) PCSrc = 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: the stimulus process walks a reference model of each
// instruction's phase sequence and queues one expected output vector per cycle; a monitor
// pops and compares one vector on every falling clock edge.
module tb_mc_control_unit;

  logic       CLK, RST, Zero;
  logic [5:0] op;
  logic [2:0] state, ALUOp;
  logic       PCWre, IRWre, RegWre, mRD, mWR, InsMemRW;
  logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
  logic [1:0] PCSrc, RegDst;

  mc_control_unit dut (
    .CLK(CLK), .RST(RST), .op(op), .Zero(Zero), .state(state), .ALUOp(ALUOp),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
    .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .PCSrc(PCSrc), .RegDst(RegDst)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Phase codes equal the external state codes; HALT is a bench-only code.
  localparam int PH_IF = 0, PH_ID = 1, PH_EXLS = 2, PH_MEM = 3, PH_WBLD = 4;
  localparam int PH_EXBR = 5, PH_EXAL = 6, PH_WBAL = 7, PH_HALT = 8;
  localparam int CAL = 0, CLD = 1, CST = 2, CBR = 3, CJ = 4, CILL = 5, CHALT = 6;
  localparam int CJAL = 7, CJR = 8;

  typedef struct {
    logic [20:0] v;
    string       name;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;

  function automatic int classify(logic [5:0] o);
    case (o)
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
      6'b011000, 6'b100110, 6'b100111: return CAL;
      6'b110001: return CLD;
      6'b110000: return CST;
      6'b110100, 6'b110101: return CBR;
      6'b111000: return CJ;
      6'b111111: return CHALT;
`ifdef MC_JAL_EN
      6'b111010: return CJAL;
      6'b111001: return CJR;
`endif
      default: return CILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] o);
    case (o)
      6'b000001, 6'b110100, 6'b110101: return 3'b001;
      6'b011000:                       return 3'b100;
      6'b010000, 6'b010010:            return 3'b101;
      6'b010001:                       return 3'b110;
      6'b100110, 6'b100111:            return 3'b111;
      default:                         return 3'b000;
    endcase
  endfunction

  // Expected output vector for one cycle of instruction o in phase ph.
  function automatic logic [20:0] model(logic [5:0] o, int ph, bit fin, bit z);
    logic [2:0] st, alu;
    logic pcw, irw, rw, rd, wr, im, sa, sb, ex, db, wd;
    logic [1:0] pcs, rdst;
    int c;
    c = classify(o);
    st = (ph == PH_HALT) ? 3'b001 : 3'(ph);
    alu = 3'b000; pcw = 0; irw = 0; rw = 0; rd = 0; wr = 0; im = 0;
    sa = 0; sb = 0; ex = 1; db = 0; wd = 0; pcs = 2'b00; rdst = 2'b00;
    if (ph == PH_IF) begin
      irw = 1; im = 1;
    end else if (ph != PH_HALT) begin
      sa = (o == 6'b011000);
      sb = (o == 6'b000010) || (o == 6'b010010) || (o == 6'b100111) ||
           (o == 6'b110001) || (o == 6'b110000);
      ex = (o != 6'b010010);
      if ((o == 6'b000010) || (o == 6'b010010) || (o == 6'b100111) || (o == 6'b110001))
        rdst = 2'b01;
      else if ((o == 6'b000000) || (o == 6'b000001) || (o == 6'b010000) ||
               (o == 6'b010001) || (o == 6'b011000) || (o == 6'b100110))
        rdst = 2'b10;
      if (ph != PH_ID) alu = alu_of(o);
      pcw = fin;
      rw  = fin && (c == CAL || c == CLD || c == CJAL);
      rd  = (ph == PH_MEM) && (c == CLD);
      wr  = (ph == PH_MEM) && (c == CST);
      db  = (ph == PH_WBLD);
      wd  = (ph == PH_WBLD) || (ph == PH_WBAL);
      if (ph == PH_EXBR) begin
        if (((o == 6'b110100) && z) || ((o == 6'b110101) && !z)) pcs = 2'b01;
      end else if (fin && ph == PH_ID) begin
        if (c == CJ || c == CJAL) pcs = 2'b11;
        else if (c == CJR)        pcs = 2'b10;
      end
    end
    return {st, alu, pcw, irw, rw, rd, wr, im, sa, sb, ex, db, wd, pcs, rdst};
  endfunction

  task automatic push(input logic [20:0] v, input string n);
    exp_t e;
    e.v = v;
    e.name = n;
    expq.push_back(e);
  endtask

  // One instruction; abort_at >= 0 pulls reset in that cycle; zf >= 0 forces Zero.
  task automatic run_instr(input logic [5:0] o, input int abort_at, input int zf);
    int phs[$];
    int c;
    bit z;
    c = classify(o);
    case (c)
      CAL:     phs = '{PH_IF, PH_ID, PH_EXAL, PH_WBAL};
      CLD:     phs = '{PH_IF, PH_ID, PH_EXLS, PH_MEM, PH_WBLD};
      CST:     phs = '{PH_IF, PH_ID, PH_EXLS, PH_MEM};
      CBR:     phs = '{PH_IF, PH_ID, PH_EXBR};
      default: phs = '{PH_IF, PH_ID};
    endcase
    for (int k = 0; k < phs.size(); k++) begin
      op = (k == 0) ? o : 6'($urandom);
      z = (zf < 0) ? 1'($urandom) : 1'(zf);
      Zero = z;
      if (k == abort_at) begin
        RST = 1'b0;
        push(model(6'b0, PH_IF, 0, 0), $sformatf("abort_op%b_ph%0d", o, phs[k]));
        @(posedge CLK); #1;
        RST = 1'b1;
        return;
      end
      push(model(o, phs[k], (k == phs.size() - 1) && (c != CHALT), z),
           $sformatf("op%b_ph%0d", o, phs[k]));
      @(posedge CLK); #1;
    end
    if (c == CHALT) begin
      for (int k = 0; k < 10; k++) begin
        op = 6'($urandom);
        Zero = 1'($urandom);
        push(model(o, PH_HALT, 0, 0), $sformatf("halt_cyc%0d", k));
        @(posedge CLK); #1;
      end
      RST = 1'b0;
      push(model(6'b0, PH_IF, 0, 0), "halt_reset");
      @(posedge CLK); #1;
      RST = 1'b1;
    end
  endtask

  function automatic logic [5:0] pick_legal(int i);
    case (i)
      0: return 6'b000000;  1: return 6'b000001;  2: return 6'b000010;
      3: return 6'b010000;  4: return 6'b010001;  5: return 6'b010010;
      6: return 6'b011000;  7: return 6'b100110;  8: return 6'b100111;
      9: return 6'b110000;  10: return 6'b110001; 11: return 6'b110100;
      12: return 6'b110101; 13: return 6'b111000; 14: return 6'b111010;
      15: return 6'b111001; default: return 6'b111111;
    endcase
  endfunction

  logic [20:0] got;
  assign got = {state, ALUOp, PCWre, IRWre, RegWre, mRD, mWR, InsMemRW, ALUSrcA, ALUSrcB,
                ExtSel, DBDataSrc, WrRegDSrc, PCSrc, RegDst};

  always @(negedge CLK) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s got=%b exp=%b", e.name, got, e.v);
      end
    end
  end

  initial begin
    logic [5:0] o;
    int c, ab;
    RST = 1'b0;
    op = 6'b0;
    Zero = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    op = 6'b111111;
    push(model(6'b0, PH_IF, 0, 0), "reset_state");
    @(posedge CLK); #1;
    RST = 1'b1;

    run_instr(6'b000000, -1, -1);  // add
    run_instr(6'b110001, -1, -1);  // lw
    run_instr(6'b110100, -1, 1);   // beq, Zero=1
    run_instr(6'b110101, -1, 1);   // bne, Zero=1
    run_instr(6'b110101, -1, 0);   // bne, Zero=0
    run_instr(6'b111111, -1, -1);  // halt then reset
    run_instr(6'b110000, 3, -1);   // sw aborted in MEM
    run_instr(6'b110000, -1, -1);  // sw
    run_instr(6'b111010, -1, -1);  // jal or illegal
    run_instr(6'b111001, -1, -1);  // jr or illegal
    run_instr(6'b111000, -1, -1);  // j
    run_instr(6'b101010, -1, -1);  // illegal

    for (int n = 0; n < 80; n++) begin
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pick_legal($urandom_range(0, 16));
      c = classify(o);
      ab = (c != CHALT && $urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(o, ab, -1);
    end

    repeat (2) @(negedge CLK);
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 op  input  6  opcode from instruction register; stable from end of IF until next IF.
REQ-004 Zero  input  1  ALU zero flag, sampled combinationally in EXE_BR.
REQ-005 state  output  3  current state code: IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
REQ-006 ALUOp  output  3  ALU operation: 000 add, 001 sub, 010 unsigned lt, 100 shift B<<A, 101 or, 110 and, 111 signed lt.
REQ-007 PCWre, IRWre, RegWre, mRD, mWR, InsMemRW  output  1 each  write/read strobes, active high.
REQ-008 ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc  output  1 each  datapath selects (A: 0 rs/1 sa; B: 0 rt/1 imm; Ext: 0 zero/1 sign; DB: 0 ALU/1 mem; WrD: 0 PC+4/1 DB).
REQ-009 PCSrc  output  2  next PC: 00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
REQ-010 RegDst  output  2  write register: 00 $31, 01 rt, 10 rd.

Function
REQ-011 Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, halt 111111; all others illegal.
REQ-012 IF: IRWre=1, InsMemRW=1 for one cycle; always -> ID.
REQ-013 ID: j/illegal -> IF; halt -> HALT (internal code, state output 001, all strobes 0); beq/bne -> EXE_BR; lw/sw -> EXE_LS; others -> EXE_AL.
REQ-014 EXE_AL -> WB_AL -> IF; EXE_LS -> MEM; MEM: lw -> WB_LD, sw -> IF; WB_LD -> IF; EXE_BR -> IF.
REQ-015 PCWre=1 for exactly one cycle per instruction, in its final state (WB_AL, WB_LD, MEM for sw, EXE_BR, ID for j/illegal); never in HALT.
REQ-016 RegWre=1 only in WB_AL and WB_LD; mWR=1 only in MEM for sw; mRD=1 only in MEM for lw.
REQ-017 ALUOp: add/addi/lw/sw 000; sub/beq/bne 001; sll 100; or/ori 101; and 110; slt/slti 111; 000 in IF/ID/HALT.
REQ-018 ALUSrcA=1 only for sll; ALUSrcB=1 for addi/ori/slti/lw/sw; ExtSel=0 only for ori, else 1.
REQ-019 RegDst=01 for addi/ori/slti/lw, 10 for R-type ops; DBDataSrc=1 and WrRegDSrc=1 in WB_LD; WrRegDSrc=1 in WB_AL.
REQ-020 EXE_BR: PCSrc=01 when (beq and Zero=1) or (bne and Zero=0), else 00; ID for j: PCSrc=11; all other final states PCSrc=00.
REQ-021 Outputs are combinational from registered state, latched op and Zero; no output depends on op in IF.
REQ-022 Cycle counts: R/I arithmetic 4, lw 5, sw 4, branch 3, j 2, illegal 2.
REQ-023 op change outside IF->ID boundary has no effect: op latched internally on IF->ID edge.

Reset
REQ-024 RST low: state=IF immediately; latched op=000000; all strobes 0 except IRWre=1, InsMemRW=1 (IF outputs); PCSrc=00, ALUOp=000.
REQ-025 Reset asserted mid-instruction aborts it: no RegWre/mWR/PCWre pulse for the aborted instruction after RST falls.
REQ-026 Only reset exits HALT.

Configuration
REQ-027 MC_JAL_EN defined: jal 111010 (ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1, -> IF) and jr 111001 (ID: PCSrc=10, PCWre=1, -> IF) supported.
REQ-028 MC_JAL_EN undefined: 111010 and 111001 are illegal opcodes per REQ-013/REQ-015; no register write.

Verification
REQ-029 add (000000) from reset -> states IF,ID,EXE_AL,WB_AL,IF; ALUOp=000 in EXE_AL; RegWre=1, RegDst=10, PCWre=1 only in WB_AL.
REQ-030 lw (110001) -> IF,ID,EXE_LS,MEM,WB_LD; mRD=1 in MEM; DBDataSrc=1, RegWre=1, RegDst=01 in WB_LD; 5 cycles.
REQ-031 beq with Zero=1 -> EXE_BR PCSrc=01, ALUOp=001; bne with Zero=1 -> PCSrc=00; both PCWre=1 in EXE_BR.
REQ-032 halt (111111) -> HALT after ID; 10 further cycles: PCWre=0, RegWre=0, mWR=0; RST low -> state=000.
REQ-033 sw, RST low during MEM -> mWR drops same instant, state=IF, no PCWre pulse.
REQ-034 opcode 111010: MC_JAL_EN on -> RegWre=1, RegDst=00, PCSrc=11 in ID; off -> RegWre=0, PCSrc=00, PCWre=1, back to IF.
